weight_col_loader: RTL and testbench
====================================

// Module: weight_col_loader
// PURPOSE
//   Upstream feeder of the weight scratch pad. Gathers one full weight column from a narrow
//   valid/ready beat stream (LANES weights per beat) into a staging register. It presents the
//   column as an unpacked array and pulses wr_en once per column, gated by the pad's pad_ready.
// PARAMETERS
//   WEIGHT_ROWS   96  weights per column; must equal the scratch pad's row count
//   WEIGHT_WIDTH  5   bits per weight
//   LANES         8   weights per input beat; legal range 1..WEIGHT_ROWS
//   CNT_W         16  width of the completed-column counter
// PORTS
//   clk            in   1                    clock, rising edge
//   reset          in   1                    asynchronous, active-high
//   abort          in   1                    sync; discards the partial or held column
//   in_valid       in   1                    beat valid
//   in_ready       out  1                    beat accepted when in_valid && in_ready
//   in_data        in   LANES*WEIGHT_WIDTH   lane j = in_data[j*W +: W]
//   in_last        in   1                    final beat marker; used only with WCL_LAST_CHECK_EN
//   pad_ready      in   1                    downstream permits a column write this cycle
//   wr_en          out  1                    one-cycle write strobe to the scratch pad
//   weight_col_out out  [W-1:0] x [0:ROWS-1]  staging register, driven directly
//   col_count      out  CNT_W                completed column writes, wraps modulo 2^CNT_W
//   err            out  1                    sticky framing error (see CONFIGURATION)
// BEHAVIOUR
//   BEATS = ceil(WEIGHT_ROWS/LANES) (default 12); beat counter is $clog2(BEATS) bits, min 1.
//   Reset values: state=FILL, beat=0, staging all '0, col_count=0, err=0; wr_en=0, in_ready=1.
//   FSM states:
//     FILL: in_ready=1. An accepted beat k writes row k*LANES+j from lane j. Lanes with row
//           >= WEIGHT_ROWS (last beat only) are dropped. beat increments.
//           Acceptance of beat BEATS-1 -> HOLD, beat=0.
//     HOLD: in_ready=0; staging frozen. wr_en = pad_ready (combinational from state and pad_ready).
//           When pad_ready=1: col_count++ at that edge and the state returns to FILL.
//           The pad captures weight_col_out at that same edge.
//   Latency: final beat accepted at edge t -> wr_en high in cycle t+1 if pad_ready=1.
//     Pad memory updates at edge t+1.
//   Throughput: BEATS+1 cycles per column at full rate.
//   in_valid=0 stalls with no state change. Gaps between beats are legal.
//   Rows not rewritten keep their previous values; the full column is rewritten every pass.
//   abort=1 (highest priority after reset): next state FILL, beat=0, wr_en forced 0.
//     in_ready is forced 0 in the abort cycle. Staging is retained; col_count and err unchanged.
//   abort in HOLD with pad_ready=1: no write occurs and col_count does not increment.
//   Reset asserted mid-column or in HOLD: immediate return to the reset values; no wr_en.
//   col_count wraps from 2^CNT_W-1 to 0 with no flag.
// CONFIGURATION
//   WCL_LAST_CHECK_EN defined:
//     - On each accepted beat, err is set if in_last != (beat==BEATS-1).
//     - err is sticky until reset. Column assembly and the FSM are unaffected by the flag.
//   WCL_LAST_CHECK_EN undefined: in_last is ignored and err is tied to 0.
// STRUCTURE
//   Shared package wcl_pkg:
//     - state enum wcl_state_e {FILL, HOLD}
//     - function wcl_beats(rows, lanes) returning ceil(rows/lanes)
//     - weight_t typedef logic [WEIGHT_WIDTH-1:0], used by the scratch pad as well
//   Single module with no sub-module: lane-to-row write decode is a generate loop over rows.
//   Row r updates when state==FILL && accept && beat==r/LANES; it takes lane r%LANES.
// TESTING
//   1 Defaults; stream 12 beats, weight row r = r%32, pad_ready=1.
//     -> wr_en high for exactly one cycle, 1 cycle after beat 11.
//     -> weight_col_out[r]==r%32; col_count=1.
//   2 Column done, pad_ready=0 for 5 cycles, then 1.
//     -> in_ready=0 and wr_en=0 for 5 cycles; a single wr_en pulse follows.
//     -> beats offered during the hold are not accepted.
//   3 LANES=10 (BEATS=10). Last beat carries 0x1F on all lanes.
//     -> rows 90..95 = 0x1F; lanes 6..9 are dropped and no out-of-range write occurs.
//   4 abort after beat 5, then a fresh 12-beat column.
//     -> no wr_en for the aborted column; the new column is written intact; col_count +1 only.
//   5 Reset pulse during HOLD with pad_ready=0.
//     -> all outputs return to reset values; the next write needs a full new column.
//   6 WCL_LAST_CHECK_EN defined; in_last on beat 7.
//     -> err=1 from the next cycle and stays 1; the column still completes after beat 11.

Source files
------------

// File: rtl/wcl_pkg.sv
// Shared definitions for the weight column loader and the weight scratch pad.
//   wcl_state_e : loader FSM state (FILL gathers beats, HOLD waits for the pad)
//   weight_t    : one weight element, also used by the scratch pad
//   wcl_beats() : beats needed to cover one column, ceil(rows / lanes)
package wcl_pkg;

  localparam int unsigned WCL_WEIGHT_WIDTH = 5;

  typedef logic [WCL_WEIGHT_WIDTH-1:0] weight_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } wcl_state_e;

  function automatic int unsigned wcl_beats(input int unsigned rows, input int unsigned lanes);
    return (rows + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/weight_col_loader.sv
// weight_col_loader: gathers one weight column from a LANES-wide valid/ready beat stream into a
// staging register and strobes wr_en once per column when the scratch pad signals pad_ready.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   abort           synchronous; discards the partial or held column (staging is kept)
//   in_valid/ready  beat handshake; in_data lane j = in_data[j*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   in_last         final-beat marker, only observed when WCL_LAST_CHECK_EN is defined
//   pad_ready       pad accepts a column write this cycle
//   wr_en           one-cycle column write strobe
//   weight_col_out  staging register, one element per row
//   col_count       completed column writes, wraps silently
//   err             sticky framing error (in_last mismatch)
//
// Build option: define WCL_LAST_CHECK_EN to enable in_last framing checks; otherwise err is 0.
module weight_col_loader
  import wcl_pkg::*;
#(
  parameter int unsigned WEIGHT_ROWS  = 96,
  parameter int unsigned WEIGHT_WIDTH = 5,
  parameter int unsigned LANES        = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          abort,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*WEIGHT_WIDTH-1:0] in_data,
  input  logic                          in_last,
  input  logic                          pad_ready,
  output logic                          wr_en,
  output logic [WEIGHT_WIDTH-1:0]       weight_col_out [0:WEIGHT_ROWS-1],
  output logic [CNT_W-1:0]              col_count,
  output logic                          err
);

  localparam int unsigned BEATS = wcl_beats(WEIGHT_ROWS, LANES);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  wcl_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  col_count_q, col_count_d;
  logic              accept;
  logic              on_last_beat;

  // abort suppresses both handshakes in its cycle so nothing is accepted or written.
  assign in_ready     = (state_q == FILL) && !abort;
  assign wr_en        = (state_q == HOLD) && pad_ready && !abort;
  assign accept       = in_valid && in_ready;
  assign on_last_beat = (beat_q == LAST_BEAT);
  assign col_count    = col_count_q;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    col_count_d = col_count_q;
    if (abort) begin
      state_d = FILL;
      beat_d  = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            if (on_last_beat) begin
              state_d = HOLD;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end
        end
        HOLD: begin
          if (pad_ready) begin
            state_d     = FILL;
            col_count_d = col_count_q + CNT_W'(1);
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      beat_q      <= '0;
      col_count_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      col_count_q <= col_count_d;
    end
  end

  // Row r is loaded from lane r%LANES of beat r/LANES. Rows past WEIGHT_ROWS simply have no
  // generate instance, so surplus lanes of the final beat are dropped.
  for (genvar r = 0; r < WEIGHT_ROWS; r++) begin : g_row
    localparam int unsigned BEAT_IDX = r / LANES;
    localparam int unsigned LANE_IDX = r % LANES;

    logic [WEIGHT_WIDTH-1:0] row_q, row_d;
    logic                    row_we;

    assign row_we = accept && (beat_q == BEAT_W'(BEAT_IDX));

    always_comb begin
      row_d = row_q;
      if (row_we) begin
        row_d = in_data[LANE_IDX*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        row_q <= '0;
      end else begin
        row_q <= row_d;
      end
    end

    assign weight_col_out[r] = row_q;
  end

`ifdef WCL_LAST_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (accept && (in_last != on_last_beat)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_weight_col_loader.sv
module tb_weight_col_loader;

  localparam int ROWS    = 96;
  localparam int W       = 5;
  localparam int LA      = 8;
  localparam int LB      = 10;
  localparam int ZERO_PAT = 1000;

`ifdef WCL_LAST_CHECK_EN
  localparam bit LAST_CHK = 1'b1;
`else
  localparam bit LAST_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Instance A: default parameters
  logic            a_abort, a_valid, a_last, a_pad, a_ready, a_wr, a_err;
  logic [LA*W-1:0] a_data;
  logic [W-1:0]    a_col [0:ROWS-1];
  logic [15:0]     a_cnt;

  // Instance B: LANES=10 (ragged last beat), narrow counter to reach wrap
  logic            b_abort, b_valid, b_last, b_pad, b_ready, b_wr, b_err;
  logic [LB*W-1:0] b_data;
  logic [W-1:0]    b_col [0:ROWS-1];
  logic [1:0]      b_cnt;

  weight_col_loader u_dut_a (
    .clk(clk), .reset(reset), .abort(a_abort), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_data), .in_last(a_last), .pad_ready(a_pad), .wr_en(a_wr),
    .weight_col_out(a_col), .col_count(a_cnt), .err(a_err)
  );

  weight_col_loader #(.WEIGHT_ROWS(96), .WEIGHT_WIDTH(5), .LANES(10), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .abort(b_abort), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_last(b_last), .pad_ready(b_pad), .wr_en(b_wr),
    .weight_col_out(b_col), .col_count(b_cnt), .err(b_err)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit ab; bit v; bit l; bit pr; int pat; int beat;
    bit er; bit ew; int ec; int cp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit ab, bit v, bit l, bit pr, int pat, int beat,
                              bit er, bit ew, int ec, int cp);
    vec_t t;
    t = '{ab, v, l, pr, pat, beat, er, ew, ec, cp};
    vecs.push_back(t);
  endfunction

  function automatic void add_col(int pat, bit pr, int cnt);
    for (int k = 0; k < 12; k++) add(0, 1, k == 11, pr, pat, k, 1, 0, cnt, -1);
  endfunction

  function automatic int exp_row(int pat, int r);
    if (pat == ZERO_PAT) return 0;
    return (r + pat) % 32;
  endfunction

  function automatic logic [LA*W-1:0] beat_a(int pat, int beat);
    logic [LA*W-1:0] d;
    for (int j = 0; j < LA; j++) d[j*W +: W] = W'(exp_row(pat, beat*LA + j));
    return d;
  endfunction

  function automatic logic [LB*W-1:0] beat_b(int beat);
    logic [LB*W-1:0] d;
    for (int j = 0; j < LB; j++) d[j*W +: W] = (beat == 9) ? 5'h1F : W'((beat*LB + j) % 32);
    return d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_col_a(input string name, input int pat);
    int bad = -1;
    for (int r = 0; r < ROWS; r++)
      if (bad < 0 && a_col[r] !== W'(exp_row(pat, r))) bad = r;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d required=%0d", name, bad, a_col[bad],
               exp_row(pat, bad));
    end
  endtask

  task automatic chk_col_b(input string name);
    int bad = -1;
    int e;
    for (int r = 0; r < ROWS; r++) begin
      e = (r >= 90) ? 31 : r % 32;
      if (bad < 0 && b_col[r] !== W'(e)) bad = r;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d", name, bad, b_col[bad]);
    end
  endtask

  task automatic drive_a(bit ab, bit v, bit l, bit pr, int pat, int beat);
    a_abort = ab; a_valid = v; a_last = l; a_pad = pr; a_data = beat_a(pat, beat);
  endtask

  initial begin
    reset = 1'b1;
    drive_a(0, 0, 0, 1, 0, 0);
    b_abort = 0; b_valid = 0; b_last = 0; b_pad = 1; b_data = '0;

    // Reset values while reset is held
    #2;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_a_wr", a_wr, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_err", a_err, 0);
    chk_col_a("rst_a_col", ZERO_PAT);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_b_cnt", b_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: full-rate column, pad ready; a beat offered during HOLD is refused
    add_col(0, 1, 0);
    add(0, 1, 0, 1, 9, 0, 0, 1, 0, -1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 1, 0);
    // 2: pad stalls for 5 cycles, offered beats ignored, then one write
    add_col(3, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 9, 0, 0, 0, 1, 3);
    add(0, 0, 0, 1, 0, 0, 0, 1, 1, -1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 2, 3);
    // 4: abort after beat 5 (with a gap), then a fresh column
    for (int k = 0; k < 6; k++) begin
      add(0, 1, 0, 1, 5, k, 1, 0, 2, -1);
      if (k == 2) add(0, 0, 0, 1, 5, 0, 1, 0, 2, -1);
    end
    add(1, 1, 0, 1, 5, 6, 0, 0, 2, -1);
    add_col(7, 1, 2);
    add(0, 0, 0, 1, 0, 0, 0, 1, 2, -1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 3, 7);
    // abort while HOLD with pad_ready=1: no write, staging kept
    add_col(11, 0, 3);
    add(1, 0, 0, 1, 0, 0, 0, 0, 3, 11);
    add(0, 0, 0, 1, 0, 0, 1, 0, 3, 11);
    add_col(13, 1, 3);
    add(0, 0, 0, 1, 0, 0, 0, 1, 3, -1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 4, 13);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_a(vecs[i].ab, vecs[i].v, vecs[i].l, vecs[i].pr, vecs[i].pat, vecs[i].beat);
      #2;
      chk($sformatf("v%0d_ready", i), a_ready, vecs[i].er);
      chk($sformatf("v%0d_wr", i), a_wr, vecs[i].ew);
      chk($sformatf("v%0d_cnt", i), a_cnt, vecs[i].ec);
      chk($sformatf("v%0d_err", i), a_err, 0);
      if (vecs[i].cp >= 0) chk_col_a($sformatf("v%0d_col", i), vecs[i].cp);
    end

    // 6: in_last on beat 7 instead of 11
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive_a(0, 1, k == 7, 1, 15, k);
      #2;
      chk($sformatf("last_k%0d_ready", k), a_ready, 1);
      chk($sformatf("last_k%0d_err", k), a_err, int'(LAST_CHK && k > 7));
    end
    @(negedge clk);
    drive_a(0, 0, 0, 1, 0, 0);
    #2;
    chk("last_hold_wr", a_wr, 1);
    chk("last_hold_err", a_err, int'(LAST_CHK));
    @(negedge clk);
    #2;
    chk("last_cnt", a_cnt, 5);
    chk("last_err_sticky", a_err, int'(LAST_CHK));
    chk_col_a("last_col", 15);

    // 3: LANES=10, ragged final beat; counter wraps after 4 columns
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        b_valid = 1; b_last = (k == 9); b_data = beat_b(k);
        #2;
        chk($sformatf("b_c%0d_k%0d_ready", c, k), b_ready, 1);
        chk($sformatf("b_c%0d_k%0d_wr", c, k), b_wr, 0);
        chk($sformatf("b_c%0d_k%0d_cnt", c, k), b_cnt, c % 4);
      end
      @(negedge clk);
      b_valid = 0; b_last = 0;
      #2;
      chk($sformatf("b_c%0d_hold_wr", c), b_wr, 1);
      chk($sformatf("b_c%0d_hold_ready", c), b_ready, 0);
    end
    @(negedge clk);
    #2;
    chk("b_cnt_wrap", b_cnt, 0);
    chk("b_err", b_err, 0);
    chk_col_b("b_col");

    // 5: reset during HOLD with pad_ready=0
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive_a(0, 1, k == 11, 0, 17, k);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_a(0, 0, 0, 0, 0, 0);
      #2;
      chk($sformatf("rs_hold%0d_ready", i), a_ready, 0);
      chk($sformatf("rs_hold%0d_wr", i), a_wr, 0);
    end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rs_ready", a_ready, 1);
    chk("rs_wr", a_wr, 0);
    chk("rs_cnt", a_cnt, 0);
    chk("rs_err", a_err, 0);
    chk_col_a("rs_col", ZERO_PAT);
    a_pad = 1;
    #1;
    chk("rs_wr_pad", a_wr, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #2;
    chk("post_rs_ready", a_ready, 1);
    chk("post_rs_wr", a_wr, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive_a(0, 1, k == 11, 1, 19, k);
      #2;
      chk($sformatf("post_rs_k%0d_wr", k), a_wr, 0);
    end
    @(negedge clk);
    drive_a(0, 0, 0, 1, 0, 0);
    #2;
    chk("post_rs_hold_wr", a_wr, 1);
    @(negedge clk);
    #2;
    chk("post_rs_cnt", a_cnt, 1);
    chk_col_a("post_rs_col", 19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
